axis_frame_capture_ctrl: RTL and testbench

Frame-level capture sequencer for the RGB888 video stream, placed upstream of the RGB888→XBGR32 pixel adapter and the DMA writer.
- Under software control it starts and stops capture only on frame boundaries.
- It forwards a programmed number of whole frames, or frames continuously.
- Between captures it discards the incoming stream without back-pressuring the video source.
- It checks line/frame geometry and reports sticky errors plus frame counters to the register block.

---
 rtl/axis_frame_capture_ctrl.sv | 174 +++++++++++++++++
 tb/tb_axis_frame_capture_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_capture_ctrl.sv
// rtl/axis_frame_capture_ctrl.sv - frame-boundary capture sequencer with geometry checks (optional FRAME_GEOM_REPAIR_EN)
module axis_frame_capture_ctrl #(
    parameter int DATA_W   = 24,
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int CNT_W    = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic [CNT_W-1:0]  ctrl_frames,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              sts_busy,
    output logic              sts_frame_done,
    output logic [CNT_W-1:0]  sts_frame_cnt,
    output logic [2:0]        sts_err,
    input  logic              sts_err_clr
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_CAPTURE  = 2'd2;

    localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] frames_tgt;
    logic             stop_pend;

    logic             slice_rdy;
    logic             acc;
    logic             fwd;
    logic             sof_beat;
    logic [CNT_W-1:0] pos_x;
    logic [CNT_W-1:0] pos_y;
    logic             at_x_end;
    logic             line_end;
    logic             frame_end;
    logic [2:0]       err_set;
    logic [CNT_W-1:0] frame_cnt_nxt;
    logic             out_tlast;

    // The source is never stalled while idle; during reset it sees no ready at all.
    assign slice_rdy     = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = aresetn & ((state == ST_IDLE) | slice_rdy);
    assign sts_busy      = (state != ST_IDLE);
    assign sts_frame_cnt = frame_cnt;

    // Beat classification and geometry tracking; a start-of-frame beat is counted as position (0,0).
    always_comb begin
        acc           = s_axis_tvalid & s_axis_tready;
        fwd           = acc & ((state == ST_CAPTURE) | ((state == ST_WAIT_SOF) & s_axis_tuser));
        sof_beat      = fwd & s_axis_tuser;
        pos_x         = sof_beat ? '0 : x_cnt;
        pos_y         = sof_beat ? '0 : y_cnt;
        at_x_end      = (pos_x == X_LAST);
`ifdef FRAME_GEOM_REPAIR_EN
        line_end      = at_x_end;
        out_tlast     = at_x_end;
`else
        line_end      = s_axis_tlast | at_x_end;
        out_tlast     = s_axis_tlast;
`endif
        frame_end     = fwd & line_end & (pos_y == Y_LAST);
        err_set[0]    = fwd & s_axis_tlast & ~at_x_end;
        err_set[1]    = fwd & at_x_end & ~s_axis_tlast;
        err_set[2]    = fwd & (state == ST_CAPTURE) & s_axis_tuser & ((x_cnt != '0) | (y_cnt != '0));
        frame_cnt_nxt = frame_cnt + CNT_ONE;
    end

    // Capture sequencer: start/stop only take effect on frame boundaries.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            x_cnt      <= '0;
            y_cnt      <= '0;
            frame_cnt  <= '0;
            frames_tgt <= '0;
            stop_pend  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_start && !ctrl_stop) begin
                        state      <= ST_WAIT_SOF;
                        frame_cnt  <= '0;
                        frames_tgt <= ctrl_frames;
                        stop_pend  <= 1'b0;
                        x_cnt      <= '0;
                        y_cnt      <= '0;
                    end
                end
                ST_WAIT_SOF, ST_CAPTURE: begin
                    if (state == ST_CAPTURE && ctrl_stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (fwd) begin
                        if (line_end) begin
                            x_cnt <= '0;
                            y_cnt <= (pos_y == Y_LAST) ? '0 : pos_y + CNT_ONE;
                        end else begin
                            x_cnt <= pos_x + CNT_ONE;
                            y_cnt <= pos_y;
                        end
                        if (frame_end) begin
                            frame_cnt <= frame_cnt_nxt;
                            if (stop_pend || ctrl_stop ||
                                ((frames_tgt != '0) && (frame_cnt_nxt == frames_tgt))) begin
                                state     <= ST_IDLE;
                                stop_pend <= 1'b0;
                            end else begin
                                state <= ST_WAIT_SOF;
                            end
                        end else begin
                            state <= ST_CAPTURE;
                        end
                    end
                    // Waiting for a frame start holds nothing worth finishing, so stop is immediate.
                    if (state == ST_WAIT_SOF && ctrl_stop) begin
                        state     <= ST_IDLE;
                        stop_pend <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    stop_pend <= 1'b0;
                end
            endcase
        end
    end

    // Output register slice: load on forward, otherwise drain when the sink takes the beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (fwd) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= out_tlast;
            m_axis_tuser  <= s_axis_tuser;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Status: frame-done pulse and sticky errors where a new set beats a clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sts_frame_done <= 1'b0;
            sts_err        <= 3'b000;
        end else begin
            sts_frame_done <= frame_end;
            sts_err        <= (sts_err & ~{3{sts_err_clr}}) | err_set;
        end
    end

endmodule

// File: tb/tb_axis_frame_capture_ctrl.sv
// tb/tb_axis_frame_capture_ctrl.sv - directed self-checking bench for axis_frame_capture_ctrl
module tb_axis_frame_capture_ctrl;

    localparam int DW = 24;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int CW = 16;

    logic          aclk;
    logic          aresetn;
    logic          ctrl_start;
    logic          ctrl_stop;
    logic [CW-1:0] ctrl_frames;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          s_axis_tuser;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          sts_busy;
    logic          sts_frame_done;
    logic [CW-1:0] sts_frame_cnt;
    logic [2:0]    sts_err;
    logic          sts_err_clr;

    logic          bp_en;
    logic          tog;
    logic          rdy_main;

    int total;
    int bad;

    logic [25:0] out_q[$];
    int          done_cnt;
    int          hold_err;
    logic        prev_stall;
    logic [25:0] prev_beat;

    axis_frame_capture_ctrl #(
        .DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .ctrl_frames(ctrl_frames),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .sts_busy(sts_busy), .sts_frame_done(sts_frame_done), .sts_frame_cnt(sts_frame_cnt),
        .sts_err(sts_err), .sts_err_clr(sts_err_clr)
    );

    assign m_axis_tready = bp_en ? tog : rdy_main;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Sink-ready toggle source, used only while back-pressure is enabled.
    initial begin
        tog = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            tog = ~tog;
        end
    end

    // Output monitor: collects delivered beats, counts done pulses, checks stall stability.
    initial begin
        done_cnt   = 0;
        hold_err   = 0;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge aclk);
            if (prev_stall && m_axis_tvalid && ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== prev_beat))
                hold_err++;
            prev_stall = m_axis_tvalid & ~m_axis_tready;
            prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready)
                out_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            if (sts_frame_done)
                done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] d, input logic l, input logic u);
        bit ok;
        ok = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge aclk);
            ok = s_axis_tready;
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_px(input logic [23:0] base, input int idx);
        send(base + 24'(idx), (idx % H) == H - 1, idx == 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_axis_tvalid && n < 40) begin
            idle(1);
            n++;
        end
        if (m_axis_tvalid) chk("drain_timeout", 32'd0, 32'd1);
        idle(2);
    endtask

    task automatic check_frame(input string tag, input int start, input logic [23:0] base);
        logic [25:0] e;
        logic [25:0] g;
        for (int i = 0; i < H * V; i++) begin
            e = {(i == 0), ((i % H) == H - 1), base + 24'(i)};
            g = (start + i < out_q.size()) ? out_q[start + i] : 26'h3ffffff;
            chk(tag, 32'(g), 32'(e));
        end
    endtask

    task automatic pulse_start(input logic [CW-1:0] n);
        ctrl_frames = n;
        ctrl_start  = 1'b1;
        idle(1);
        ctrl_start  = 1'b0;
    endtask

    task automatic pulse_stop();
        ctrl_stop = 1'b1;
        idle(1);
        ctrl_stop = 1'b0;
    endtask

    int q0;
    int d0;
    int rdy_low;
    int vld_hi;
    int busy_hi;

    initial begin
        total = 0;
        bad   = 0;
        aresetn = 1'b0;
        ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_frames = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        sts_err_clr = 1'b0; bp_en = 1'b0; rdy_main = 1'b1;

        // Reset state
        idle(3);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_busy", 32'(sts_busy), 32'd0);
        chk("rst_err", 32'(sts_err), 32'd0);
        chk("rst_fcnt", 32'(sts_frame_cnt), 32'd0);
        aresetn = 1'b1;
        idle(2);

        // 1. Idle drain
        q0 = out_q.size();
        rdy_low = 0; vld_hi = 0; busy_hi = 0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata = 24'(i);
            s_axis_tuser = (i % 12) == 0;
            s_axis_tlast = (i % 4) == 3;
            @(negedge aclk);
            if (!s_axis_tready) rdy_low++;
            if (m_axis_tvalid) vld_hi++;
            if (sts_busy) busy_hi++;
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        chk("t1_tready_low", 32'(rdy_low), 32'd0);
        chk("t1_mvalid_hi", 32'(vld_hi), 32'd0);
        chk("t1_busy_hi", 32'(busy_hi), 32'd0);
        chk("t1_nout", 32'(out_q.size() - q0), 32'd0);

        // 2. Single frame, started mid-frame
        q0 = out_q.size(); d0 = done_cnt;
        pulse_start(16'd1);
        chk("t2_busy", 32'(sts_busy), 32'd1);
        for (int i = 5; i < 12; i++) send_px(24'h0000f0, i);
        chk("t2_discard", 32'(out_q.size() - q0), 32'd0);
        send_px(24'h000100, 0);
        chk("t2_latency", 32'({m_axis_tvalid, m_axis_tuser, m_axis_tdata}), 32'h3000100);
        for (int i = 1; i < 12; i++) send_px(24'h000100, i);
        for (int i = 0; i < 4; i++) send_px(24'h0001f0, i);
        drain();
        chk("t2_nout", 32'(out_q.size() - q0), 32'd12);
        check_frame("t2_beat", q0, 24'h000100);
        chk("t2_done", 32'(done_cnt - d0), 32'd1);
        chk("t2_fcnt", 32'(sts_frame_cnt), 32'd1);
        chk("t2_busy_end", 32'(sts_busy), 32'd0);
        chk("t2_err", 32'(sts_err), 32'd0);

        // 3. Back-pressure, continuous mode
        q0 = out_q.size(); d0 = done_cnt;
        pulse_start(16'd0);
        bp_en = 1'b1;
        for (int i = 0; i < 12; i++) send_px(24'h000200, i);
        for (int i = 0; i < 12; i++) send_px(24'h000300, i);
        bp_en = 1'b0;
        drain();
        chk("t3_nout", 32'(out_q.size() - q0), 32'd24);
        check_frame("t3_f0", q0, 24'h000200);
        check_frame("t3_f1", q0 + 12, 24'h000300);
        chk("t3_hold", 32'(hold_err), 32'd0);
        chk("t3_done", 32'(done_cnt - d0), 32'd2);
        chk("t3_fcnt", 32'(sts_frame_cnt), 32'd2);
        chk("t3_busy", 32'(sts_busy), 32'd1);
        pulse_stop();
        chk("t3_stop_idle", 32'(sts_busy), 32'd0);

        // 4. Stop mid-frame
        q0 = out_q.size();
        pulse_start(16'd0);
        for (int i = 0; i < 5; i++) send_px(24'h000400, i);
        pulse_stop();
        chk("t4_pending_busy", 32'(sts_busy), 32'd1);
        for (int i = 5; i < 12; i++) send_px(24'h000400, i);
        for (int i = 0; i < 12; i++) send_px(24'h000500, i);
        drain();
        chk("t4_nout", 32'(out_q.size() - q0), 32'd12);
        check_frame("t4_beat", q0, 24'h000400);
        chk("t4_busy", 32'(sts_busy), 32'd0);
        chk("t4_fcnt", 32'(sts_frame_cnt), 32'd1);

        // 5. Geometry errors
        pulse_start(16'd0);
        send(24'h000600, 1'b0, 1'b1);
        send(24'h000601, 1'b0, 1'b0);
        send(24'h000602, 1'b1, 1'b0);
        chk("t5_early", 32'(sts_err), 32'd1);
        for (int i = 3; i < 7; i++) send(24'h000600 + 24'(i), 1'b0, 1'b0);
        chk("t5_late", 32'(sts_err), 32'd3);
        send(24'h000607, 1'b0, 1'b0);
        send(24'h000608, 1'b0, 1'b1);
        chk("t5_midsof", 32'(sts_err), 32'd7);
        chk("t5_fcnt", 32'(sts_frame_cnt), 32'd0);
        sts_err_clr = 1'b1;
        idle(1);
        sts_err_clr = 1'b0;
        chk("t5_clr", 32'(sts_err), 32'd0);
        chk("t5_busy", 32'(sts_busy), 32'd1);

        // 6. Async reset with a stalled output beat
        rdy_main = 1'b0;
        send(24'h000609, 1'b0, 1'b0);
        chk("t6_stalled", 32'({m_axis_tvalid, m_axis_tdata}), 32'h1000609);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_mvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t6_mdata", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'd0);
        chk("t6_tready", 32'(s_axis_tready), 32'd0);
        chk("t6_sts", 32'({sts_busy, sts_frame_done, sts_err, sts_frame_cnt}), 32'd0);
        idle(2);
        aresetn = 1'b1;
        rdy_main = 1'b1;
        idle(1);
        chk("t6_rel_tready", 32'(s_axis_tready), 32'd1);
        chk("t6_rel_busy", 32'(sts_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
